// File: rtl/rd_port_40x64b_1_to_8_arb.sv
// rd_port_40x64b_1_to_8_arb
//
// Round-robin read-port arbiter for the 40x64b register file. Eight requesters
// share the file's single read port. Each granted read is tracked through the
// array's one-cycle read latency, and its data is returned to the requester
// that issued it.
//
// Ports
//   clk                 clock, rising edge
//   rst                 asynchronous active-low reset
//   rd_req[7:0]         per-port request, held until that port's rd_ack
//   rd_addr[47:0]       per-port address, port i in [6i+5:6i]
//   rd_ack[7:0]         registered one-cycle grant pulse, at most one hot
//   rd_data_valid[7:0]  one-hot data-return pulse to the owning port
//   rd_err              returned read was out of range (addr >= DEPTH)
//   rd_data[63:0]       return data, zero unless a good read is returned
//   muxed_port_rd_en    registered read enable to the storage array
//   muxed_port_rd_addr  registered read address to the storage array
//   muxed_port_rd_data  storage data, valid the cycle after muxed_port_rd_en
module rd_port_40x64b_1_to_8_arb #(
  parameter int NUM_PORTS  = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 40
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            rd_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_PORTS-1:0]            rd_ack,
  output logic [NUM_PORTS-1:0]            rd_data_valid,
  output logic                            rd_err,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            muxed_port_rd_en,
  output logic [ADDR_WIDTH-1:0]           muxed_port_rd_addr,
  input  logic [DATA_WIDTH-1:0]           muxed_port_rd_data
);

  // The pointer is exactly log2(NUM_PORTS) wide, so the round-robin
  // wrap mod 8 falls out of the natural overflow of the addition.
  localparam int PTR_W = $clog2(NUM_PORTS);

  logic [PTR_W-1:0]      ptr_q;
  logic [NUM_PORTS-1:0]  eligible_p0;
  logic                  vld_p0;
  logic [PTR_W-1:0]      gnt_idx_p0;
  logic [ADDR_WIDTH-1:0] gnt_addr_p0;
  logic                  oor_p0;

  logic [NUM_PORTS-1:0]  owner_p1;
  logic                  err_p1;
  logic [NUM_PORTS-1:0]  owner_p2;
  logic                  err_p2;

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_PORTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // ---- stage 0: eligibility and round-robin pick ----
  // A port whose ack is visible this cycle is masked. This prevents a second
  // grant while the requester is still dropping its request.
  always_comb begin
    eligible_p0 = rd_req & ~rd_ack;
    vld_p0      = 1'b0;
    gnt_idx_p0  = ptr_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!vld_p0 && eligible_p0[ptr_q + PTR_W'(k)]) begin
        vld_p0     = 1'b1;
        gnt_idx_p0 = ptr_q + PTR_W'(k);
      end
    end
  end

  assign gnt_addr_p0 = rd_addr[gnt_idx_p0*ADDR_WIDTH +: ADDR_WIDTH];
  assign oor_p0      = (gnt_addr_p0 >= ADDR_WIDTH'(DEPTH));

  // ---- stage 1: grant, array request, owner tracking ----
  // An out-of-range read is still acked and tracked, so the requester gets its
  // return pulse. The array itself is never enabled for that read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ack             <= '0;
      ptr_q              <= '0;
      muxed_port_rd_en   <= 1'b0;
      muxed_port_rd_addr <= '0;
      owner_p1           <= '0;
      err_p1             <= 1'b0;
    end else if (vld_p0) begin
      rd_ack             <= onehot(gnt_idx_p0);
      ptr_q              <= gnt_idx_p0 + PTR_W'(1);
      muxed_port_rd_en   <= ~oor_p0;
      muxed_port_rd_addr <= gnt_addr_p0;
      owner_p1           <= onehot(gnt_idx_p0);
      err_p1             <= oor_p0;
    end else begin
      rd_ack             <= '0;
      muxed_port_rd_en   <= 1'b0;
      owner_p1           <= '0;
      err_p1             <= 1'b0;
    end
  end

  // ---- stage 2: aligned with array read data ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_p2 <= '0;
      err_p2   <= 1'b0;
    end else begin
      owner_p2 <= owner_p1;
      err_p2   <= err_p1;
    end
  end

  // Array data is forwarded only for a good read. Returns with no valid
  // read and out-of-range returns both drive zero, so a floating array
  // bus never reaches the clients.
  assign rd_data_valid = owner_p2;
  assign rd_err        = err_p2;
  assign rd_data       = ((|owner_p2) && !err_p2) ? muxed_port_rd_data : '0;

endmodule
